conv_feeder: RTL

- Hardware front end that drives the conv_mix convolution core in place of a bench.
- On a go pulse it raises start and shifts the kernel weights into conv_mix bit-serially.
- It then streams feature-map pixels from a synchronous pixel RAM whenever conv_mix raises din_ready, and holds start until conv_mix reports done.
- Sits between the layer sequencer / feature-map buffers and conv_mix in the BNN datapath.

---
 rtl/conv_feeder_if.sv | 36 +++
 rtl/conv_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/conv_feeder_if.sv
// Signal bundle between conv_feeder and its environment (sequencer, pixel RAM, conv_mix).
// master is the feeder; slave is everything around it.
interface conv_feeder_if #(
  parameter int DATA_W      = 32,
  parameter int WEIGHT_BITS = 25,
  parameter int ADDR_W      = 10
);
  logic                     go;
  logic                     mode;
  logic [WEIGHT_BITS-1:0]   weight_word;
  logic [ADDR_W-1:0]        pix_addr;
  logic                     pix_rd;
  logic signed [DATA_W-1:0] pix_rdata;
  logic                     conv_start;
  logic                     conv_state;
  logic                     conv_weight_en;
  logic                     conv_weight;
  logic signed [DATA_W-1:0] conv_din;
  logic                     conv_din_ready;
  logic                     conv_done;
  logic                     busy;
  logic                     frame_done;
  logic                     err;

  modport master (
    input  go, mode, weight_word, pix_rdata, conv_din_ready, conv_done,
    output pix_addr, pix_rd, conv_start, conv_state, conv_weight_en, conv_weight,
           conv_din, busy, frame_done, err
  );

  modport slave (
    output go, mode, weight_word, pix_rdata, conv_din_ready, conv_done,
    input  pix_addr, pix_rd, conv_start, conv_state, conv_weight_en, conv_weight,
           conv_din, busy, frame_done, err
  );
endinterface

// File: rtl/conv_feeder.sv
// Front end for conv_mix: shifts a binary kernel in bit-serially, then streams
// pixels from a synchronous RAM on each din_ready until conv_mix reports done.
module conv_feeder #(
  parameter int DATA_W      = 32,
  parameter int WEIGHT_BITS = 25,
  parameter int PIX_CNT0    = 784,
  parameter int PIX_CNT1    = 144,
  parameter int ADDR_W      = 10
) (
  input logic           clk,
  input logic           rst,
  conv_feeder_if.master bus
);
  localparam int                WCNT_W    = $clog2(WEIGHT_BITS + 1);
  localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(WEIGHT_BITS);
  localparam logic [ADDR_W-1:0] LAST0     = ADDR_W'(PIX_CNT0 - 1);
  localparam logic [ADDR_W-1:0] LAST1     = ADDR_W'(PIX_CNT1 - 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, WAIT_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [WEIGHT_BITS-1:0]   wsh_q, wsh_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]        pcnt_q, pcnt_d;
  logic                     conv_start_q, conv_start_d;
  logic                     weight_en_q, weight_en_d;
  logic                     weight_bit_q, weight_bit_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     err_q, err_d;
  logic                     rd_d1_q, rd_d1_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;

  logic rd_en;
  logic last_pix;

  // A done in the same cycle as din_ready aborts the frame, so no read is issued.
  assign rd_en    = (state_q == STREAM) && bus.conv_din_ready && !bus.conv_done;
  assign last_pix = (pcnt_q == (mode_q ? LAST1 : LAST0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.go) state_d = LOAD_W;
      LOAD_W:    if (bus.conv_done) state_d = IDLE;
                 else if (wcnt_q == WCNT_FULL) state_d = STREAM;
      STREAM:    if (bus.conv_done) state_d = IDLE;
                 else if (rd_en && last_pix) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.conv_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d       = mode_q;
    wsh_d        = wsh_q;
    wcnt_d       = wcnt_q;
    pcnt_d       = pcnt_q;
    conv_start_d = conv_start_q;
    weight_en_d  = weight_en_q;
    weight_bit_d = weight_bit_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    rd_d1_d      = rd_en;
    hold_d       = rd_d1_q ? bus.pix_rdata : hold_q;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          mode_d       = bus.mode;
          wsh_d        = bus.weight_word >> 1;
          weight_bit_d = bus.weight_word[0];
          weight_en_d  = 1'b1;
          wcnt_d       = WCNT_W'(1);
          pcnt_d       = '0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          conv_start_d = 1'b1;
        end
      end
      LOAD_W: begin
        if (bus.conv_din_ready) err_d = 1'b1;
        if (bus.conv_done) begin
          err_d        = 1'b1;
          conv_start_d = 1'b0;
          weight_en_d  = 1'b0;
          busy_d       = 1'b0;
        end else if (wcnt_q != WCNT_FULL) begin
          weight_bit_d = wsh_q[0];
          wsh_d        = wsh_q >> 1;
          wcnt_d       = wcnt_q + WCNT_W'(1);
        end else begin
          weight_en_d  = 1'b0;
        end
      end
      STREAM: begin
        if (bus.conv_done) begin
          err_d        = 1'b1;
          conv_start_d = 1'b0;
          busy_d       = 1'b0;
        end else if (rd_en) begin
          pcnt_d = last_pix ? '0 : pcnt_q + ADDR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.conv_din_ready) err_d = 1'b1;
        if (bus.conv_done) begin
          conv_start_d = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= 1'b0;
      wsh_q        <= '0;
      wcnt_q       <= '0;
      pcnt_q       <= '0;
      conv_start_q <= 1'b0;
      weight_en_q  <= 1'b0;
      weight_bit_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      rd_d1_q      <= 1'b0;
      hold_q       <= '0;
    end else begin
      mode_q       <= mode_d;
      wsh_q        <= wsh_d;
      wcnt_q       <= wcnt_d;
      pcnt_q       <= pcnt_d;
      conv_start_q <= conv_start_d;
      weight_en_q  <= weight_en_d;
      weight_bit_q <= weight_bit_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      rd_d1_q      <= rd_d1_d;
      hold_q       <= hold_d;
    end
  end

  // Fresh RAM data passes straight through; otherwise the last captured word is held.
  assign bus.conv_din       = rd_d1_q ? bus.pix_rdata : hold_q;
  assign bus.pix_rd         = rd_en;
  assign bus.pix_addr       = pcnt_q;
  assign bus.conv_start     = conv_start_q;
  assign bus.conv_state     = mode_q;
  assign bus.conv_weight_en = weight_en_q;
  assign bus.conv_weight    = weight_bit_q;
  assign bus.busy           = busy_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.err            = err_q;
endmodule
